uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_fifo.sv | 50 +++++
 rtl/uart_fifo.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state encodings, register bit layout and parity helper for the FIFO-buffered UART.
package uart_pkg;

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
    typedef enum logic [0:0] {TxIdle, TxShift} tx_state_e;

    // Status word bit positions; 9:8 keep their legacy busy/valid placement.
    localparam int unsigned StatValid  = 8;
    localparam int unsigned StatTxFull = 9;
    localparam int unsigned StatTxIdle = 10;
    localparam int unsigned StatOvr    = 11;
    localparam int unsigned StatFerr   = 12;
    localparam int unsigned StatPerr   = 13;

    // Control word bit positions.
    localparam int unsigned CtlClrErr = 0;
    localparam int unsigned CtlFlush  = 1;

    // mode 1 = even, 2 = odd; callers only use this when parity is enabled.
    function automatic logic parity_bit(input logic [7:0] d, input int unsigned mode);
        return (mode == 2) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; a pop makes room for a push in the same cycle, even when full.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= din;
    end

endmodule

// File: rtl/uart_fifo.sv
// UART with RX/TX FIFOs behind a two-register bus interface (data and status/control).
module uart_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FREQ_MHZ = 12,
    parameter int unsigned BAUDS    = 115200,
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned PARITY   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rstrb,
    input  logic        wstrb,
    input  logic        sel_dat,
    input  logic        sel_cntl,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        RXD,
    output logic        TXD,
    output logic        brk
);

    localparam int unsigned   DIV       = FREQ_MHZ * 1000000 / BAUDS;
    localparam int unsigned   CW        = $clog2(DIV);
    localparam logic [CW-1:0] DivLast   = CW'(DIV - 1);
    localparam logic [CW-1:0] HalfLast  = CW'(DIV / 2 - 1);
    localparam logic [3:0]    TxLastBit = (PARITY != 0) ? 4'd10 : 4'd9;

    // Bus decode
    logic tx_push, rx_pop, ctl_wr, clr_err, flush, fifo_reset;
    assign tx_push    = sel_dat && wstrb;
    assign rx_pop     = sel_dat && rstrb;
    assign ctl_wr     = sel_cntl && wstrb;
    assign clr_err    = ctl_wr && wdata[CtlClrErr];
    assign flush      = ctl_wr && wdata[CtlFlush];
    assign fifo_reset = reset || flush;

    logic       rx_push, rx_full, rx_empty;
    logic [7:0] rx_shift, rx_dout;
    logic       tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic unused_count;
    assign unused_count = ^{rx_count, tx_count};

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (fifo_reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_shift),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (fifo_reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    logic rxd_meta, rxd_sync;
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
        end
    end

    rx_state_e     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic          rx_bad, ferr_set, perr_set;

    // rx_push fires the cycle after the stop sample; rx_shift is stable until the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RxIdle;
            rx_cnt   <= HalfLast;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_bad   <= 1'b0;
            rx_push  <= 1'b0;
            ferr_set <= 1'b0;
            perr_set <= 1'b0;
            brk      <= 1'b0;
        end else begin
            rx_push  <= 1'b0;
            ferr_set <= 1'b0;
            perr_set <= 1'b0;
            brk      <= 1'b0;
            unique case (rx_state)
                RxIdle: begin
                    if (!rxd_sync) begin
                        rx_state <= RxStart;
                        rx_cnt   <= HalfLast;
                    end
                end
                RxStart: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else if (rxd_sync) begin
                        rx_state <= RxIdle;
                    end else begin
                        rx_state <= RxData;
                        rx_cnt   <= DivLast;
                        rx_bit   <= '0;
                        rx_bad   <= 1'b0;
                    end
                end
                RxData: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_shift <= {rxd_sync, rx_shift[7:1]};
                        rx_cnt   <= DivLast;
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= (PARITY != 0) ? RxParity : RxStop;
                    end
                end
                RxParity: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_cnt   <= DivLast;
                        rx_state <= RxStop;
                        if (rxd_sync != parity_bit(rx_shift, PARITY)) begin
                            perr_set <= 1'b1;
                            rx_bad   <= 1'b1;
                        end
                    end
                end
                RxStop: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_state <= RxIdle;
                        if (!rxd_sync) begin
                            ferr_set <= 1'b1;
                        end else if (!rx_bad) begin
                            rx_push <= 1'b1;
                            brk     <= (rx_shift == 8'h03);
                        end
                    end
                end
                default: rx_state <= RxIdle;
            endcase
        end
    end

    // A push that finds the FIFO full is only lost if no pop frees a slot this cycle.
    logic ovr_set, ovr, ferr, perr;
    assign ovr_set = rx_push && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
            perr <= 1'b0;
        end else begin
            ovr  <= ovr_set  || (ovr  && !clr_err);
            ferr <= ferr_set || (ferr && !clr_err);
            perr <= perr_set || (perr && !clr_err);
        end
    end

    tx_state_e     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [10:0]   tx_frame, tx_load;
    logic          tx_last;

    // Reloading straight from the end of a stop bit keeps consecutive frames gap-free.
    always_comb begin
        tx_last = (tx_state == TxShift) && (tx_cnt == '0) && (tx_bit == TxLastBit);
        tx_pop  = !tx_empty && ((tx_state == TxIdle) || tx_last);
        tx_load = (PARITY != 0) ? {1'b1, parity_bit(tx_dout, PARITY), tx_dout, 1'b0}
                                : {2'b11, tx_dout, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TxIdle;
            tx_cnt   <= DivLast;
            tx_bit   <= '0;
            tx_frame <= '1;
            TXD      <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= TxShift;
            tx_cnt   <= DivLast;
            tx_bit   <= '0;
            tx_frame <= tx_load;
            TXD      <= 1'b0;
        end else begin
            case (tx_state)
                TxIdle: TXD <= 1'b1;
                TxShift: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else if (tx_bit == TxLastBit) begin
                        tx_state <= TxIdle;
                        TXD      <= 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 4'd1;
                        tx_cnt   <= DivLast;
                        tx_frame <= {1'b1, tx_frame[10:1]};
                        TXD      <= tx_frame[1];
                    end
                end
                default: tx_state <= TxIdle;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (sel_dat || sel_cntl) begin
            if (sel_dat) rdata[7:0] = rx_dout;
            rdata[StatValid]  = !rx_empty;
            rdata[StatTxFull] = tx_full;
            rdata[StatTxIdle] = (tx_state == TxIdle) && tx_empty;
            rdata[StatOvr]    = ovr;
            rdata[StatFerr]   = ferr;
            rdata[StatPerr]   = perr;
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: random bytes through both directions against queue-based line/FIFO models.
module tb_uart_fifo;

    localparam int unsigned DIV = 104;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rstrb = 1'b0, wstrb = 1'b0;
    logic        sel_dat = 1'b0, sel_cntl = 1'b0, sel_dat_p = 1'b0, sel_cntl_p = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata, rdata_p;
    logic        rxd = 1'b1, rxd_p = 1'b1;
    logic        txd, txd_p, brk, brk_p;

    int total = 0;
    int bad = 0;
    int unsigned cyc = 0;
    int brk_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (brk === 1'b1) brk_cnt <= brk_cnt + 1;

    uart_fifo dut (
        .clk(clk), .reset(reset), .rstrb(rstrb), .wstrb(wstrb), .sel_dat(sel_dat),
        .sel_cntl(sel_cntl), .wdata(wdata), .rdata(rdata), .RXD(rxd), .TXD(txd), .brk(brk)
    );

    uart_fifo #(.PARITY(1)) dut_p (
        .clk(clk), .reset(reset), .rstrb(rstrb), .wstrb(wstrb), .sel_dat(sel_dat_p),
        .sel_cntl(sel_cntl_p), .wdata(wdata), .rdata(rdata_p), .RXD(rxd_p), .TXD(txd_p),
        .brk(brk_p)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Bus tasks start just after a falling edge and leave the bench there.
    task automatic reg_read(input bit p, input bit dat, output logic [31:0] v);
        if (p) begin sel_dat_p = dat; sel_cntl_p = !dat; end
        else begin sel_dat = dat; sel_cntl = !dat; end
        #1 v = p ? rdata_p : rdata;
        sel_dat = 0; sel_cntl = 0; sel_dat_p = 0; sel_cntl_p = 0;
    endtask

    task automatic reg_write(input bit p, input bit dat, input logic [31:0] d);
        if (p) begin sel_dat_p = dat; sel_cntl_p = !dat; end
        else begin sel_dat = dat; sel_cntl = !dat; end
        wdata = d;
        wstrb = 1'b1;
        @(negedge clk);
        wstrb = 1'b0;
        sel_dat = 0; sel_cntl = 0; sel_dat_p = 0; sel_cntl_p = 0;
    endtask

    task automatic rx_pop_head(input bit p);
        if (p) sel_dat_p = 1'b1; else sel_dat = 1'b1;
        rstrb = 1'b1;
        @(negedge clk);
        rstrb = 1'b0;
        sel_dat = 0; sel_dat_p = 0;
    endtask

    task automatic line_bit(input bit p, input logic v);
        if (p) rxd_p = v; else rxd = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic rx_send(input bit p, input logic [7:0] d, input bit with_par,
                           input logic par, input logic stop);
        line_bit(p, 1'b0);
        for (int i = 0; i < 8; i++) line_bit(p, d[i]);
        if (with_par) line_bit(p, par);
        line_bit(p, stop);
        if (p) rxd_p = 1'b1; else rxd = 1'b1;
    endtask

    // Line monitor: decodes every frame on TXD by mid-bit sampling.
    logic [7:0]  mon_q[$];
    int unsigned mon_t[$];
    int          mon_stop_bad = 0;
    initial begin : tx_mon
        logic [7:0]  d;
        int unsigned t0;
        forever begin
            @(negedge txd);
            @(negedge clk);
            t0 = cyc;
            repeat (DIV / 2 - 1) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk);
                d[i] = txd;
            end
            repeat (DIV) @(negedge clk);
            if (txd !== 1'b1) mon_stop_bad++;
            mon_q.push_back(d);
            mon_t.push_back(t0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  b;
        logic [7:0]  exp_q[$];
        logic [7:0]  rx_model[$];
        int          errs, t, b0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check_eq("rst_txd", txd, 1'b1);
        check_eq("rst_brk", brk, 1'b0);
        check_eq("rst_txd_p", txd_p, 1'b1);
        check_eq("rst_brk_p", brk_p, 1'b0);
        reg_read(0, 0, v); check_eq("rst_status", v, 32'h400);
        reg_read(1, 0, v); check_eq("rst_status_p", v, 32'h400);
        check_eq("nosel_rdata", rdata, 32'h0);

        // 0x55 waveform, bit by bit
        @(negedge clk);
        reg_write(0, 1, 32'h55);
        check_eq("tx55_pre", txd, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            errs = 0;
            for (int c = 0; c < DIV; c++) begin
                if (txd !== 1'(k % 2)) errs++;
                @(negedge clk);
            end
            check_eq($sformatf("tx55_bit%0d", k), errs, 0);
        end
        reg_read(0, 0, v); check_eq("tx55_done", v, 32'h400);

        // 17 back-to-back random TX bytes
        mon_q.delete(); mon_t.delete(); mon_stop_bad = 0;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            reg_write(0, 1, {24'h0, b});
        end
        reg_read(0, 0, v); check_eq("tx17_full", v, 32'h200);
        t = 0;
        while (mon_q.size() < 17 && t < 17 * 10 * DIV + 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("tx17_count", mon_q.size(), 17);
        for (int i = 0; i < 17 && i < mon_q.size(); i++)
            check_eq($sformatf("tx17_byte%0d", i), mon_q[i], exp_q[i]);
        check_eq("tx17_stop", mon_stop_bad, 0);
        for (int i = 1; i < mon_t.size(); i++)
            check_eq($sformatf("tx17_gap%0d", i),
                     (mon_t[i] - mon_t[i-1] == 10 * DIV) || (mon_t[i] - mon_t[i-1] == 10 * DIV + 1),
                     1);

        // Ctrl-C frame
        repeat (200) @(negedge clk);
        b0 = brk_cnt;
        rx_send(0, 8'h03, 0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check_eq("brk_pulses", brk_cnt - b0, 1);
        reg_read(0, 1, v); check_eq("brk_data", v, 32'h503);
        rx_pop_head(0);
        reg_read(0, 0, v); check_eq("brk_popped", v, 32'h400);

        // 17 RX frames without reading: overrun
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom_range(0, 255));
            if (rx_model.size() < 16) rx_model.push_back(b);
            rx_send(0, b, 0, 1'b0, 1'b1);
        end
        repeat (5) @(negedge clk);
        reg_read(0, 0, v); check_eq("ovr_status", v, 32'hD00);
        for (int i = 0; i < 16; i++) begin
            reg_read(0, 1, v);
            check_eq($sformatf("rx_byte%0d", i), v[7:0], rx_model.pop_front());
            rx_pop_head(0);
        end
        reg_read(0, 0, v); check_eq("ovr_drained", v, 32'hC00);
        reg_write(0, 0, 32'h1);
        reg_read(0, 0, v); check_eq("ovr_cleared", v, 32'h400);

        // Framing error, then a short glitch
        b = 8'($urandom_range(0, 255));
        rx_send(0, b, 0, 1'b0, 1'b0);
        repeat (150) @(negedge clk);
        reg_read(0, 0, v); check_eq("ferr_status", v, 32'h1400);
        reg_write(0, 0, 32'h1);
        rxd = 1'b0;
        repeat (30) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        reg_read(0, 0, v); check_eq("glitch_status", v, 32'h400);

        // Even parity: bad parity on 0x01, then a good random byte
        rx_send(1, 8'h01, 1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        reg_read(1, 0, v); check_eq("perr_status", v, 32'h2400);
        reg_write(1, 0, 32'h1);
        b = 8'($urandom_range(0, 255));
        rx_send(1, b, 1, ^b, 1'b1);
        repeat (5) @(negedge clk);
        reg_read(1, 1, v); check_eq("par_good", v, 32'h500 | {24'h0, b});

        // Reset in the middle of a TX frame with data queued both ways
        b = 8'($urandom_range(0, 255));
        rx_send(0, b, 0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        reg_read(0, 1, v); check_eq("pre_rst_rx", v, 32'h500 | {24'h0, b});
        @(negedge clk);
        for (int i = 0; i < 3; i++) reg_write(0, 1, $urandom_range(0, 255));
        repeat (300) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_txd", txd, 1'b1);
        reset = 1'b0;
        reg_read(0, 0, v); check_eq("rst_mid_status", v, 32'h400);
        reg_read(1, 0, v); check_eq("rst_mid_status_p", v, 32'h400);
        repeat (2 * DIV) @(negedge clk);
        check_eq("rst_mid_txd_idle", txd, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
